// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding, a one-cycle
// load-use bubble, squash on flush, freeze on hold and a saturating stall counter.
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_ra,
  input  logic [4:0]        id_rb,
  input  logic [4:0]        id_rw,
  input  logic              id_use_rb,
  input  logic [31:0]       id_bus_a,
  input  logic [31:0]       id_bus_b,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       ex_alu_result,
  input  logic              mem_valid,
  input  logic              mem_reg_wr,
  input  logic [4:0]        mem_rw,
  input  logic [31:0]       mem_data,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rw,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [31:0]       ex_imm,
  output logic              stall_o,
  output logic [15:0]       stall_cnt
);

  logic ex_alu_wr;
  logic ex_load;
  logic ex_hit_a;
  logic ex_hit_b;
  logic mem_hit_a;
  logic mem_hit_b;
  logic load_use;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // A load in EX has no data yet, so it is never a forwarding source; it stalls instead.
  assign ex_alu_wr = ex_valid & ex_ctrl[0] & ~ex_ctrl[1];
  assign ex_load   = ex_valid & ex_ctrl[0] & ex_ctrl[1];

  assign ex_hit_a  = ex_alu_wr & (ex_rw == id_ra) & (id_ra != 5'd0);
  assign ex_hit_b  = ex_alu_wr & (ex_rw == id_rb) & (id_rb != 5'd0);
  assign mem_hit_a = mem_valid & mem_reg_wr & (mem_rw == id_ra) & (id_ra != 5'd0);
  assign mem_hit_b = mem_valid & mem_reg_wr & (mem_rw == id_rb) & (id_rb != 5'd0);

  always_comb begin
    fwd_a = id_bus_a;
    if (ex_hit_a)
      fwd_a = ex_alu_result;
    else if (mem_hit_a)
      fwd_a = mem_data;
  end

  always_comb begin
    fwd_b = id_bus_b;
    if (id_use_rb) begin
      if (ex_hit_b)
        fwd_b = ex_alu_result;
      else if (mem_hit_b)
        fwd_b = mem_data;
    end
  end

  assign load_use = id_valid & ex_load & (ex_rw != 5'd0) &
                    ((ex_rw == id_ra) | (id_use_rb & (ex_rw == id_rb)));

  assign stall_o = hold_i | (load_use & ~flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (stall_o && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Flush outranks hold, which outranks the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc    <= 32'd0;
      ex_rw    <= 5'd0;
      ex_ctrl  <= '0;
      ex_op_a  <= 32'd0;
      ex_op_b  <= 32'd0;
      ex_imm   <= 32'd0;
    end else if (flush_i || (!hold_i && load_use)) begin
      ex_valid <= 1'b0;
      ex_pc    <= 32'd0;
      ex_rw    <= 5'd0;
      ex_ctrl  <= '0;
      ex_op_a  <= 32'd0;
      ex_op_b  <= 32'd0;
      ex_imm   <= 32'd0;
    end else if (!hold_i) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rw    <= id_rw;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_op_a  <= fwd_a;
      ex_op_b  <= fwd_b;
      ex_imm   <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage, plus hand sequences for
// reset-during-hold, first edge after reset release, and stall counter saturation.
module tb_id_ex_stage;

  localparam int CTRL_W = 8;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_ra;
  logic [4:0]        id_rb;
  logic [4:0]        id_rw;
  logic              id_use_rb;
  logic [31:0]       id_bus_a;
  logic [31:0]       id_bus_b;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       ex_alu_result;
  logic              mem_valid;
  logic              mem_reg_wr;
  logic [4:0]        mem_rw;
  logic [31:0]       mem_data;
  logic              hold_i;
  logic              flush_i;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rw;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_op_a;
  logic [31:0]       ex_op_b;
  logic [31:0]       ex_imm;
  logic              stall_o;
  logic [15:0]       stall_cnt;

  int total;
  int bad;

  id_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_ra(id_ra), .id_rb(id_rb), .id_rw(id_rw),
    .id_use_rb(id_use_rb), .id_bus_a(id_bus_a), .id_bus_b(id_bus_b), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_alu_result(ex_alu_result),
    .mem_valid(mem_valid), .mem_reg_wr(mem_reg_wr), .mem_rw(mem_rw), .mem_data(mem_data),
    .hold_i(hold_i), .flush_i(flush_i),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rw(ex_rw), .ex_ctrl(ex_ctrl),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] valid, pc, ra, rb, rw, use_rb, bus_a, bus_b, imm, ctrl, alu;
    logic [31:0] mv, mwr, mrw, mdata, hold, flush;
    logic [31:0] e_stall, e_valid, e_pc, e_rw, e_ctrl, e_a, e_b, e_imm, e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] v, input logic [31:0] pc,
                          input logic [31:0] rw, input logic [31:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [31:0] cnt);
    checkOutput({tag, " ex_valid"},  {31'd0, ex_valid}, v);
    checkOutput({tag, " ex_pc"},     ex_pc, pc);
    checkOutput({tag, " ex_rw"},     {27'd0, ex_rw}, rw);
    checkOutput({tag, " ex_ctrl"},   {24'd0, ex_ctrl}, ctrl);
    checkOutput({tag, " ex_op_a"},   ex_op_a, a);
    checkOutput({tag, " ex_op_b"},   ex_op_b, b);
    checkOutput({tag, " ex_imm"},    ex_imm, imm);
    checkOutput({tag, " stall_cnt"}, {16'd0, stall_cnt}, cnt);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    id_valid      = v.valid[0];
    id_pc         = v.pc;
    id_ra         = v.ra[4:0];
    id_rb         = v.rb[4:0];
    id_rw         = v.rw[4:0];
    id_use_rb     = v.use_rb[0];
    id_bus_a      = v.bus_a;
    id_bus_b      = v.bus_b;
    id_imm        = v.imm;
    id_ctrl       = v.ctrl[CTRL_W-1:0];
    ex_alu_result = v.alu;
    mem_valid     = v.mv[0];
    mem_reg_wr    = v.mwr[0];
    mem_rw        = v.mrw[4:0];
    mem_data      = v.mdata;
    hold_i        = v.hold[0];
    flush_i       = v.flush[0];
    #1;
    checkOutput({tag, " stall_o"}, {31'd0, stall_o}, v.e_stall);
    @(posedge clk);
    #1;
    checkAll(tag, v.e_valid, v.e_pc, v.e_rw, v.e_ctrl, v.e_a, v.e_b, v.e_imm, v.e_cnt);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Columns: valid pc ra rb rw use_rb bus_a bus_b imm ctrl alu | mv mwr mrw mdata | hold flush |
    //          exp: stall valid pc rw ctrl op_a op_b imm cnt
    tbl[0]  = '{1,'h100,1,2,3,1,'hA,'hB,'h5,'h81,0,       0,0,0,0,      0,0, 0,1,'h100,3,'h81,'hA,'hB,'h5,0};
    tbl[1]  = '{1,'h104,3,6,7,1,'hDEAD,'h60,'h1,'h01,'h11,0,0,0,0,      0,0, 0,1,'h104,7,'h01,'h11,'h60,'h1,0};
    tbl[2]  = '{1,'h108,8,5,5,1,'h80,'h55,'h2,'h01,'h77,  1,1,5,'h22,   0,0, 0,1,'h108,5,'h01,'h80,'h22,'h2,0};
    tbl[3]  = '{1,'h10C,9,5,0,1,'h90,'h55,'h3,'h01,'h33,  1,1,5,'h22,   0,0, 0,1,'h10C,0,'h01,'h90,'h33,'h3,0};
    tbl[4]  = '{1,'h110,0,0,4,1,0,'hB0,'h40,'h03,'h99,    1,1,0,'h88,   0,0, 0,1,'h110,4,'h03,0,'hB0,'h40,0};
    tbl[5]  = '{1,'h114,4,1,6,1,'hDEAD,'h10,'h4,'h01,'h1000,0,0,0,0,    0,0, 1,0,0,0,0,0,0,0,1};
    tbl[6]  = '{1,'h114,4,1,6,1,'hDEAD,'h10,'h4,'h01,0,   1,1,4,'h44,   0,0, 0,1,'h114,6,'h01,'h44,'h10,'h4,1};
    tbl[7]  = '{1,'h118,2,6,4,0,'h20,'h66,'h8,'h03,'hAA,  0,0,0,0,      0,0, 0,1,'h118,4,'h03,'h20,'h66,'h8,1};
    tbl[8]  = '{1,'h11C,1,4,9,0,'h1,'h4,'h9,'h01,'h200,   0,0,0,0,      0,0, 0,1,'h11C,9,'h01,'h1,'h4,'h9,1};
    tbl[9]  = '{1,'h120,1,2,4,1,'h1,'h2,'h0,'h03,'h300,   0,0,0,0,      0,0, 0,1,'h120,4,'h03,'h1,'h2,0,1};
    tbl[10] = '{1,'h124,4,0,5,0,'hDEAD,0,'hA,'h01,'h400,  0,0,0,0,      0,1, 0,0,0,0,0,0,0,0,1};
    tbl[11] = '{1,'h128,1,2,10,1,'h11,'h22,'h7,'h85,0,    0,0,0,0,      0,0, 0,1,'h128,10,'h85,'h11,'h22,'h7,1};
    tbl[12] = '{1,'h200,10,10,11,1,'hF1,'hF2,'hF3,'h01,'h123,1,1,10,'h456, 1,0, 1,1,'h128,10,'h85,'h11,'h22,'h7,2};
    tbl[13] = '{1,'h200,10,10,11,1,'hF1,'hF2,'hF3,'h01,'h123,1,1,10,'h456, 1,0, 1,1,'h128,10,'h85,'h11,'h22,'h7,3};
    tbl[14] = '{1,'h200,10,10,11,1,'hF1,'hF2,'hF3,'h01,'h123,1,1,10,'h456, 1,0, 1,1,'h128,10,'h85,'h11,'h22,'h7,4};
    tbl[15] = '{1,'h200,10,10,11,1,'hF1,'hF2,'hF3,'h01,'h123,1,1,10,'h456, 1,1, 1,0,0,0,0,0,0,0,5};
    tbl[16] = '{0,'h300,1,2,12,1,'h31,'h32,'h33,'h81,0,   0,0,0,0,      0,0, 0,0,'h300,12,0,'h31,'h32,'h33,5};
    tbl[17] = '{1,'h400,1,2,13,1,'h41,'h42,'h43,'h01,0,   0,0,0,0,      0,0, 0,1,'h400,13,'h01,'h41,'h42,'h43,5};

    rst_n = 1'b0; id_valid = 1'b0; id_pc = '0; id_ra = '0; id_rb = '0; id_rw = '0;
    id_use_rb = 1'b0; id_bus_a = '0; id_bus_b = '0; id_imm = '0; id_ctrl = '0;
    ex_alu_result = '0; mem_valid = 1'b0; mem_reg_wr = 1'b0; mem_rw = '0; mem_data = '0;
    hold_i = 1'b1; flush_i = 1'b0;
    #2;
    checkOutput("reset stall_o=hold", {31'd0, stall_o}, 32'd1);
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    hold_i = 1'b0;
    #1;
    checkOutput("reset stall_o idle", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) applyStimulus(i, tbl[i]);

    // Freeze on a valid instruction, then drop reset between edges.
    @(negedge clk);
    hold_i = 1'b1;
    @(posedge clk);
    #1;
    checkAll("hold1", 1, 'h400, 13, 'h01, 'h41, 'h42, 'h43, 6);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midreset stall_o", {31'd0, stall_o}, 32'd1);

    // First edge after release: stale EX r13 must not forward.
    @(negedge clk);
    rst_n = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    id_valid = 1'b1; id_pc = 32'h500; id_ra = 5'd13; id_rb = 5'd2; id_rw = 5'd14;
    id_use_rb = 1'b0; id_bus_a = 32'h55; id_bus_b = 32'h56; id_imm = 32'h57; id_ctrl = 8'h01;
    ex_alu_result = 32'h999; mem_valid = 1'b0; mem_reg_wr = 1'b0;
    @(posedge clk);
    #1;
    checkAll("release", 1, 'h500, 14, 'h01, 'h55, 'h56, 'h57, 0);

    // Long hold to drive the counter into saturation.
    @(negedge clk);
    hold_i = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("stall_cnt saturate", {16'd0, stall_cnt}, 32'hFFFF);
    checkOutput("saturate frozen pc", ex_pc, 32'h500);
    @(negedge clk);
    hold_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage CPU. Captures the register-file read buses (busA/busB) plus decode fields on each rising edge and presents them to the ALU. It resolves RAW hazards by forwarding from the EX and MEM stages, and inserts one bubble on load-use. The register file writes on the falling edge, so WB-stage results are already visible on busA/busB and are not forwarded here.

## Interface
- CTRL_W, 8, width of the opaque decode control word; bit0 = reg_wr, bit1 = mem_rd, bit2 = mem_wr, the rest pass through.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  32  PC of the decode instruction.
- id_ra, id_rb, id_rw  in  5 each  source A, source B, destination.
- id_use_rb  in  1  rb is a true source (0 for immediate forms).
- id_bus_a, id_bus_b  in  32 each  register-file read data for ra and rb.
- id_imm  in  32  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  decode control word.
- ex_alu_result  in  32  combinational ALU result for the instruction currently held in this stage.
- mem_valid, mem_reg_wr  in  1 each  MEM-stage instruction is valid and writes a register.
- mem_rw  in  5  MEM-stage destination.
- mem_data  in  32  MEM-stage writeback value (load data or ALU result).
- hold_i  in  1  downstream stall: freeze this stage.
- flush_i  in  1  branch/jump resolved taken: squash.
- ex_valid  out  1; ex_pc  out  32; ex_rw  out  5; ex_ctrl  out  CTRL_W.
- ex_op_a, ex_op_b  out  32 each  forwarded operands.
- ex_imm  out  32.
- stall_o  out  1  combinational; tells IF/ID to hold.
- stall_cnt  out  16  saturating count of cycles with stall_o=1.

## Operation
- Forwarding, per operand X in {a, b}, with source register rX:
  - EX hit: ex_valid & ex_ctrl[0] & !ex_ctrl[1] & ex_rw==rX & rX!=0. Selects ex_alu_result.
  - Else MEM hit: mem_valid & mem_reg_wr & mem_rw==rX & rX!=0. Selects mem_data.
  - Else selects id_bus_X.
  - EX has priority over MEM. Operand b uses forwarding only when id_use_rb=1; otherwise it takes id_bus_b unchanged.
- Load-use: load_use = id_valid & ex_valid & ex_ctrl[0] & ex_ctrl[1] & ex_rw!=0 & (ex_rw==id_ra | (id_use_rb & ex_rw==id_rb)).
- stall_o = hold_i | (load_use & !flush_i).
- Next-state priority at each rising edge:
  1. flush_i: bubble. ex_valid=0, ex_ctrl=0; other fields don't-care (implementation drives 0).
  2. hold_i: all outputs hold their values.
  3. load_use: bubble.
  4. Otherwise: load the decode fields and the forwarded operands; ex_valid=id_valid; ex_ctrl=id_ctrl when id_valid, else 0.
- stall_cnt increments on each rising edge where stall_o=1 and saturates at 0xFFFF.

## Timing
- Reset (rst_n low, asynchronous): ex_valid, ex_pc, ex_rw, ex_ctrl, ex_op_a, ex_op_b, ex_imm and stall_cnt all go to 0. stall_o then equals hold_i.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and its data is forwarded via mem_data.
- Flush and load_use in the same cycle: flush wins and stall_o stays 0 unless hold_i=1.
- Flush and hold in the same cycle: flush wins and the stage squashes. stall_o=1 because of hold_i.
- Reset released mid-stream: the first edge after release behaves as normal operation from an all-bubble state.
- Register 0 is never forwarded; reads of r0 always take id_bus_X.

## Test plan
- EX forward: instruction 1 = add r3 (result 0x11). Instruction 2 reads ra=r3 with id_bus_a=0xDEAD -> ex_op_a=0x11 on the next edge.
- MEM-over-bus and EX-over-MEM priority:
  - r5 matches MEM only, mem_data=0x22 -> ex_op_b=0x22.
  - r5 also matches EX, ex_alu_result=0x33 -> ex_op_b=0x33.
- Load-use: lw r4 is in EX and the ID instruction reads r4 -> stall_o=1 for one cycle and a bubble enters (ex_valid=0). Next edge latches mem_data=0x44 into ex_op_a; stall_cnt=1.
- r0 and id_use_rb:
  - EX writes r0 and ID reads r0 with id_bus_a=0 -> ex_op_a=0.
  - id_use_rb=0 with an EX match on rb -> no forward and no stall.
- Flush/hold:
  - flush_i together with load_use -> bubble, stall_o=0.
  - hold_i for 3 cycles -> outputs frozen, stall_cnt +3.
  - rst_n low mid-hold -> all outputs 0 immediately.
